fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the fetch stage against a handshaked instruction memory: holds the fetch PC, issues one request per instruction and waits for the data.
- Arbitrates the redirect sources (interrupt/exception entry, ERET, branch) and kills in-flight fetches that a redirect makes stale.
- Presents one fetched instruction with its PC and fetch exception code to F/D, held under downstream stall.
- Sits between the pipeline control unit and the IM port; replaces the free-running single-cycle PC register.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset.
- EXC_PC, 32'h0000_4180, interrupt/exception handler entry.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- int_req  in  1  interrupt/exception redirect request.
- eret_req  in  1  ERET redirect request.
- epc  in  32  ERET target.
- br_req  in  1  branch/jump redirect request.
- br_target  in  32  branch/jump target.
- stall  in  1  downstream not ready; hold presented instruction.
- im_req  out  1  IM request valid.
- im_addr  out  32  IM request address.
- im_gnt  in  1  IM accepted request this cycle.
- im_rvalid  in  1  IM read data valid.
- im_rdata  in  32  IM read data.
- f_valid  out  1  f_pc/f_instr/f_exc_code valid.
- f_pc  out  32  PC of presented instruction.
- f_instr  out  32  presented instruction.
- f_exc_code  out  5  5'h0 normal, 5'h4 AdEL on fetch.

Behaviour:
- Reset (reset==0, async):
  - state=FETCH, pc=RESET_PC, kill=0.
  - Outputs: f_valid=0, f_instr=0, f_exc_code=0, f_pc=RESET_PC, im_req=0.
  - Reset asserted mid-WAIT abandons the transaction; any later im_rvalid is not consumed until state re-enters WAIT.
- Redirect target:
  - Priority int_req > eret_req > br_req; targets EXC_PC / epc / br_target.
  - A redirect applies in every state regardless of stall.
  - Any redirect sets pc<=target and f_valid<=0 on the next edge.
- Address check: pc is legal iff pc[1:0]==0 and IM_LO<=pc<=IM_HI.
- FETCH:
  - Legal pc: im_req=1 and im_addr=pc (both from registers, combinational out). im_req and im_addr are held stable until im_gnt.
  - On im_gnt: state goes to WAIT.
  - Illegal pc: im_req=0. Next state is DONE with f_instr=0, f_exc_code=5'h4, f_pc=pc.
  - Redirect in the same cycle as im_gnt: state goes to WAIT with kill=1 and pc=target.
  - Redirect without im_gnt: stay in FETCH with the new pc.
- WAIT:
  - im_req=0.
  - On im_rvalid with kill==0: f_instr<=im_rdata, f_pc<=pc, f_exc_code<=0, f_valid<=1, state goes to DONE.
  - On im_rvalid with kill==1: discard the data, kill<=0, state goes to FETCH.
  - Redirect in WAIT: kill<=1, pc<=target.
  - Redirect coincident with im_rvalid: discard the data, go to FETCH with the new pc.
- DONE:
  - f_valid=1 and outputs held while stall==1.
  - stall==0 and no redirect: pc<=pc+4 (wraps mod 2^32), f_valid<=0, state goes to FETCH.
  - Redirect: go to FETCH with target; f_valid<=0.
- Latency: with zero-wait IM (gnt in FETCH, rvalid the next cycle), one instruction every 3 cycles.
- There is never more than one outstanding IM transaction.

Optional Feature:
- Macro FETCH_SEQ_PERF_EN.
- When defined:
  - Adds output ports perf_fetch_cnt (32) and perf_kill_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on each DONE entry, including AdEL entries.
  - perf_kill_cnt increments on each discarded im_rvalid.
  - Both counters wrap at 2^32.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - the state enum (FETCH, WAIT, DONE);
  - EXC_ADEL=5'h4 and EXC_NONE=5'h0;
  - the default RESET_PC, EXC_PC, IM_LO and IM_HI constants.
- One sub-module, fetch_redirect_arb: a combinational priority select producing redir_valid and redir_target.

Test Plan:
- Reset release with IM granting immediately and rvalid one cycle later returning 32'h3c01_0001 → f_valid high, f_pc=32'h3000, f_instr=32'h3c01_0001, f_exc_code=0; next request goes to 32'h3004.
- Stall held 5 cycles in DONE → outputs unchanged and im_req=0 throughout; on release the request goes to pc+4.
- br_req with target 32'h3100 while in WAIT (rvalid arrives 2 cycles later) → data discarded, f_valid stays 0, next im_addr=32'h3100; with FETCH_SEQ_PERF_EN, perf_kill_cnt=1.
- int_req, eret_req and br_req in the same cycle, epc=32'h3200 → next pc=32'h4180.
- br_target 32'h3002, then separately 32'h7000 → no im_req; f_valid=1, f_exc_code=5'h4, f_instr=0, f_pc equal to the target.
- reset driven low mid-WAIT, then a stray rvalid arrives → outputs reset immediately; the stray rvalid is ignored; fetch restarts at 32'h3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, fetch
// exception codes, default address map and the fetch-address legality check.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0]  EXC_NONE     = 5'h0;
  localparam logic [4:0]  EXC_ADEL     = 5'h4;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] DEF_IM_LO    = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_HI    = 32'h0000_6ffc;

  // Word aligned and inside the instruction memory window.
  function automatic logic pc_legal(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (pc[1:0] == 2'b00) && (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/fetch_redirect_arb.sv
// Priority select of the redirect sources: interrupt/exception entry, then
// ERET, then branch/jump.
module fetch_redirect_arb
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_PC = DEF_EXC_PC
) (
  input  logic        int_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        br_req,
  input  logic [31:0] br_target,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  // Highest-priority active request wins the target.
  always_comb begin
    redir_valid  = int_req | eret_req | br_req;
    redir_target = 32'h0;
    if (int_req) begin
      redir_target = EXC_PC;
    end else if (eret_req) begin
      redir_target = epc;
    end else if (br_req) begin
      redir_target = br_target;
    end else begin
      redir_target = 32'h0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer against a handshaked IM port with redirect kill.
// Optional performance counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
  parameter logic [31:0] IM_LO    = DEF_IM_LO,
  parameter logic [31:0] IM_HI    = DEF_IM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic [4:0]  f_exc_code
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_kill_cnt
`endif
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic        kill_r;
  logic        redir_valid_s;
  logic [31:0] redir_target_s;
  logic        pc_ok_s;
  logic        capture_s;
  logic        drop_s;
  logic        adel_s;

  fetch_redirect_arb #(.EXC_PC(EXC_PC)) u_arb (
    .int_req      (int_req),
    .eret_req     (eret_req),
    .epc          (epc),
    .br_req       (br_req),
    .br_target    (br_target),
    .redir_valid  (redir_valid_s),
    .redir_target (redir_target_s)
  );

  assign pc_ok_s = pc_legal(pc_r, IM_LO, IM_HI);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a grant only counts when a legal request was shown.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH: begin
        if (pc_ok_s && im_gnt) begin
          state_nxt_s = WAIT;
        end else if (!pc_ok_s && !redir_valid_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      WAIT: begin
        if (im_rvalid) begin
          state_nxt_s = (redir_valid_s || kill_r) ? FETCH : DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        if (redir_valid_s || !stall) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = FETCH;
    endcase
  end

  // IM request and internal event strobes; im_req is forced low during reset.
  always_comb begin
    im_req    = reset && (state_r == FETCH) && pc_ok_s;
    im_addr   = pc_r;
    capture_s = (state_r == WAIT) && im_rvalid && !kill_r && !redir_valid_s;
    drop_s    = (state_r == WAIT) && im_rvalid && (kill_r || redir_valid_s);
    adel_s    = (state_r == FETCH) && !pc_ok_s && !redir_valid_s;
  end

  // PC, kill flag and the presented F/D instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      kill_r     <= 1'b0;
      f_valid    <= 1'b0;
      f_pc       <= RESET_PC;
      f_instr    <= 32'h0;
      f_exc_code <= EXC_NONE;
    end else begin
      if (redir_valid_s) begin
        pc_r <= redir_target_s;
      end else if (state_r == DONE && !stall) begin
        pc_r <= pc_r + 32'd4;
      end

      // A redirect that lands while a grant or response is outstanding must
      // suppress the response that is still on its way.
      if (state_r == FETCH && redir_valid_s && pc_ok_s && im_gnt) begin
        kill_r <= 1'b1;
      end else if (state_r == WAIT && im_rvalid) begin
        kill_r <= 1'b0;
      end else if (state_r == WAIT && redir_valid_s) begin
        kill_r <= 1'b1;
      end

      if (redir_valid_s) begin
        f_valid <= 1'b0;
      end else if (capture_s || adel_s) begin
        f_valid <= 1'b1;
      end else if (state_r == DONE && !stall) begin
        f_valid <= 1'b0;
      end

      if (capture_s) begin
        f_instr    <= im_rdata;
        f_pc       <= pc_r;
        f_exc_code <= EXC_NONE;
      end else if (adel_s) begin
        f_instr    <= 32'h0;
        f_pc       <= pc_r;
        f_exc_code <= EXC_ADEL;
      end
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  // Completed fetches (including AdEL) and discarded responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= 32'h0;
      perf_kill_cnt  <= 32'h0;
    end else begin
      if (capture_s || adel_s) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (drop_s) begin
        perf_kill_cnt <= perf_kill_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-driven IM handshakes, redirects,
// stall, AdEL and reset-mid-transaction. Honours FETCH_SEQ_PERF_EN.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        int_req;
  logic        eret_req;
  logic [31:0] epc;
  logic        br_req;
  logic [31:0] br_target;
  logic        stall;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic [4:0]  f_exc_code;
`ifdef FETCH_SEQ_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_kill_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  fetch_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .int_req    (int_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .br_req     (br_req),
    .br_target  (br_target),
    .stall      (stall),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_gnt     (im_gnt),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .f_valid    (f_valid),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .f_exc_code (f_exc_code)
`ifdef FETCH_SEQ_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 32'h%08h, expected 32'h%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [4:0] exc);
    check({tag, "_valid"}, {31'h0, f_valid}, {31'h0, v});
    check({tag, "_pc"},    f_pc, pc);
    check({tag, "_instr"}, f_instr, instr);
    check({tag, "_exc"},   {27'h0, f_exc_code}, {27'h0, exc});
  endtask

  initial begin
    reset = 1'b0; int_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
    br_req = 1'b0; br_target = 32'h0; stall = 1'b0;
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = 32'h0;

    // Reset state
    tick(); tick();
    check_out("rst", 1'b0, 32'h0000_3000, 32'h0, 5'h0);
    check("rst_im_req", {31'h0, im_req}, 32'h0);

    // First fetch with zero-wait IM
    @(negedge clk); reset = 1'b1; #1;
    check("f1_req",  {31'h0, im_req}, 32'h1);
    check("f1_addr", im_addr, 32'h0000_3000);
    im_gnt = 1'b1; tick(); im_gnt = 1'b0;
    check("f1_wait_req", {31'h0, im_req}, 32'h0);
    im_rvalid = 1'b1; im_rdata = 32'h3c01_0001; tick(); im_rvalid = 1'b0;
    check_out("f1", 1'b1, 32'h0000_3000, 32'h3c01_0001, 5'h0);
    tick();
    check("f2_req",   {31'h0, im_req}, 32'h1);
    check("f2_addr",  im_addr, 32'h0000_3004);
    check("f2_valid", {31'h0, f_valid}, 32'h0);

    // Stall held 5 cycles in DONE
    im_gnt = 1'b1; tick(); im_gnt = 1'b0;
    im_rvalid = 1'b1; im_rdata = 32'h2001_0005; stall = 1'b1; tick(); im_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_out("stall", 1'b1, 32'h0000_3004, 32'h2001_0005, 5'h0);
      check("stall_req", {31'h0, im_req}, 32'h0);
      tick();
    end
    stall = 1'b0; tick();
    check("unstall_req",  {31'h0, im_req}, 32'h1);
    check("unstall_addr", im_addr, 32'h0000_3008);

    // Branch while in WAIT; late response discarded
    im_gnt = 1'b1; tick(); im_gnt = 1'b0;
    br_req = 1'b1; br_target = 32'h0000_3100; tick(); br_req = 1'b0;
    check("kill_valid0", {31'h0, f_valid}, 32'h0);
    check("kill_req0",   {31'h0, im_req}, 32'h0);
    tick();
    im_rvalid = 1'b1; im_rdata = 32'hdead_beef; tick(); im_rvalid = 1'b0;
    check("kill_valid1", {31'h0, f_valid}, 32'h0);
    check("kill_req1",   {31'h0, im_req}, 32'h1);
    check("kill_addr",   im_addr, 32'h0000_3100);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_kill", perf_kill_cnt, 32'd1);
`endif

    // All three redirects at once: interrupt wins
    int_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_3200;
    br_req = 1'b1; br_target = 32'h0000_3300; tick();
    int_req = 1'b0; eret_req = 1'b0; br_req = 1'b0;
    check("prio_addr", im_addr, 32'h0000_4180);
    check("prio_req",  {31'h0, im_req}, 32'h1);

    // Misaligned target -> AdEL
    br_req = 1'b1; br_target = 32'h0000_3002; tick(); br_req = 1'b0;
    check("adel1_req", {31'h0, im_req}, 32'h0);
    tick();
    check_out("adel1", 1'b1, 32'h0000_3002, 32'h0, 5'h4);

    // Redirect out of DONE to an out-of-range target -> AdEL
    br_req = 1'b1; br_target = 32'h0000_7000; tick(); br_req = 1'b0;
    check("adel2_valid0", {31'h0, f_valid}, 32'h0);
    check("adel2_req",    {31'h0, im_req}, 32'h0);
    tick();
    check_out("adel2", 1'b1, 32'h0000_7000, 32'h0, 5'h4);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_fetch", perf_fetch_cnt, 32'd4);
`endif
    br_req = 1'b1; br_target = 32'h0000_3010; tick(); br_req = 1'b0;
    check("pre_rst_addr", im_addr, 32'h0000_3010);

    // Reset mid-WAIT, then a stray response
    im_gnt = 1'b1; tick(); im_gnt = 1'b0;
    check("mid_wait_req", {31'h0, im_req}, 32'h0);
    reset = 1'b0; #1;
    check_out("mid_rst", 1'b0, 32'h0000_3000, 32'h0, 5'h0);
    check("mid_rst_req", {31'h0, im_req}, 32'h0);
    @(negedge clk); reset = 1'b1; #1;
`ifdef FETCH_SEQ_PERF_EN
    check("perf_fetch_rst", perf_fetch_cnt, 32'd0);
    check("perf_kill_rst",  perf_kill_cnt, 32'd0);
`endif
    im_rvalid = 1'b1; im_rdata = 32'hbad0_bad0; tick(); im_rvalid = 1'b0;
    check("stray_valid", {31'h0, f_valid}, 32'h0);
    check("stray_req",   {31'h0, im_req}, 32'h1);
    check("stray_addr",  im_addr, 32'h0000_3000);
    im_gnt = 1'b1; tick(); im_gnt = 1'b0;
    im_rvalid = 1'b1; im_rdata = 32'h3c01_0001; tick(); im_rvalid = 1'b0;
    check_out("restart", 1'b1, 32'h0000_3000, 32'h3c01_0001, 5'h0);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_fetch_end", perf_fetch_cnt, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
